// File: rtl/wb_gain_ctrl_pkg.sv
// ============================================================================
// wb_gain_ctrl_pkg : shared colour codes, Q8.8 gain constants and FSM states
// Revision 1.0
// ============================================================================
`default_nettype none

package wb_gain_ctrl_pkg;

    localparam logic [1:0] COLOR_RED   = 2'd0;
    localparam logic [1:0] COLOR_GREEN = 2'd1;
    localparam logic [1:0] COLOR_BLUE  = 2'd2;

    localparam int GAIN_W    = 16;
    localparam int GAIN_FRAC = 8;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h0100;

    // One load cycle plus one iteration per quotient bit
    localparam logic [4:0] DIV_LAST_CYC = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIV_R  = 2'd1,
        ST_DIV_B  = 2'd2,
        ST_UPDATE = 2'd3
    } awb_state_t;

    function automatic logic [GAIN_W-1:0] clamp_gain(
        input logic [GAIN_W-1:0] q,
        input logic              sat,
        input logic [GAIN_W-1:0] max_gain
    );
        return (sat || (q > max_gain)) ? max_gain : q;
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_gain_ctrl_if.sv
// ============================================================================
// wb_gain_ctrl_if : Bayer pixel stream in, white-balance gains out
// Revision 1.0
// ============================================================================
`default_nettype none

interface wb_gain_ctrl_if;
    logic        valid_i;
    logic [1:0]  color_i;
    logic [7:0]  value_i;
    logic        last_i;
    logic [15:0] K_R;
    logic [15:0] K_G;
    logic [15:0] K_B;
    logic        valid_gain_o;

    modport master (
        output valid_i, color_i, value_i, last_i,
        input  K_R, K_G, K_B, valid_gain_o
    );

    modport slave (
        input  valid_i, color_i, value_i, last_i,
        output K_R, K_G, K_B, valid_gain_o
    );
endinterface

`default_nettype wire

// File: rtl/wb_serial_div.sv
// ============================================================================
// wb_serial_div : restoring divider, 16-bit quotient MSB first, with overflow
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_serial_div
    import wb_gain_ctrl_pkg::*;
#(
    parameter int SUM_W = 32
) (
    input  wire logic                      clk,
    input  wire logic                      rst_n,
    input  wire logic                      start,
    input  wire logic [SUM_W+GAIN_FRAC-1:0] n,
    input  wire logic [SUM_W-1:0]          d,
    output logic                           done,
    output logic [GAIN_W-1:0]              quotient,
    output logic                           sat
);

    localparam int N_W = SUM_W + GAIN_FRAC;

    logic [SUM_W-1:0]  rem;
    logic [GAIN_W-1:0] low;
    logic [4:0]        cnt;
    logic [SUM_W-1:0]  n_hi;
    logic [SUM_W:0]    trial;
    logic              ge;

    // Upper part of N seeds the remainder; it is < D unless the quotient overflows
    assign n_hi  = {{(GAIN_W-GAIN_FRAC){1'b0}}, n[N_W-1:GAIN_W]};
    assign trial = {rem, low[GAIN_W-1]};
    assign ge    = (trial >= {1'b0, d});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            low      <= '0;
            cnt      <= '0;
            quotient <= '0;
            sat      <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            rem      <= n_hi;
            low      <= n[GAIN_W-1:0];
            cnt      <= 5'(GAIN_W);
            quotient <= '0;
            sat      <= (d == '0) || (n_hi >= d);
            done     <= 1'b0;
        end else if (cnt != 5'd0) begin
            rem      <= ge ? (trial[SUM_W-1:0] - d) : trial[SUM_W-1:0];
            low      <= {low[GAIN_W-2:0], 1'b0};
            quotient <= {quotient[GAIN_W-2:0], ge};
            cnt      <= cnt - 5'd1;
            done     <= (cnt == 5'd1);
        end else begin
            done     <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/wb_gain_ctrl.sv
// ============================================================================
// wb_gain_ctrl : gray-world AWB statistics and R/B gain computation vs green
// Revision 1.0
// ============================================================================
`default_nettype none

module wb_gain_ctrl
    import wb_gain_ctrl_pkg::*;
#(
    parameter int          SUM_W    = 32,
    parameter logic [15:0] MAX_GAIN = 16'h0FF0
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    input  wire logic     awb_en_i,
    wb_gain_ctrl_if.slave bus,
    output logic          busy_o,
    output logic          frame_drop_o
);

    logic [SUM_W-1:0] sum_r, sum_g, sum_b;
    logic [SUM_W-1:0] nxt_r, nxt_g, nxt_b;
    logic [SUM_W:0]   value_ext;
    logic             beat;
    logic             frame_end;

    awb_state_t        state;
    logic [4:0]        cnt;
    logic [SUM_W-1:0]  op_r, op_b;
    logic [SUM_W-2:0]  op_g_half;
    logic [GAIN_W-1:0] res_r;

    logic                      div_start;
    logic [SUM_W+GAIN_FRAC-1:0] div_n;
    logic [SUM_W-1:0]          div_d;
    logic                      div_done;
    logic [GAIN_W-1:0]         div_q;
    logic                      div_sat;
    logic [GAIN_W-1:0]         div_gain;

    function automatic logic [SUM_W-1:0] sat_add(
        input logic [SUM_W-1:0] a,
        input logic [SUM_W:0]   b
    );
        logic [SUM_W:0] s;
        s = {1'b0, a} + b;
        return s[SUM_W] ? {SUM_W{1'b1}} : s[SUM_W-1:0];
    endfunction

    assign value_ext = {{(SUM_W-7){1'b0}}, bus.value_i};
    assign beat      = bus.valid_i & awb_en_i;
    assign frame_end = beat & bus.last_i;

    always_comb begin
        nxt_r = sum_r;
        nxt_g = sum_g;
        nxt_b = sum_b;
        if (beat) begin
            case (bus.color_i)
                COLOR_RED:   nxt_r = sat_add(sum_r, value_ext);
                COLOR_GREEN: nxt_g = sat_add(sum_g, value_ext);
                COLOR_BLUE:  nxt_b = sat_add(sum_b, value_ext);
                default:     ;
            endcase
        end
    end

    // Live sums keep running in every state; a frame end always restarts them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else if (frame_end) begin
            sum_r <= '0;
            sum_g <= '0;
            sum_b <= '0;
        end else begin
            sum_r <= nxt_r;
            sum_g <= nxt_g;
            sum_b <= nxt_b;
        end
    end

    // Green is halved because an RGGB quad carries two green samples
    assign div_n     = {1'b0, op_g_half, {GAIN_FRAC{1'b0}}};
    assign div_d     = (state == ST_DIV_B) ? op_b : op_r;
    assign div_start = ((state == ST_DIV_R) || (state == ST_DIV_B)) && (cnt == 5'd0);
    assign div_gain  = clamp_gain(div_q, div_sat, MAX_GAIN);

    wb_serial_div #(
        .SUM_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .n        (div_n),
        .d        (div_d),
        .done     (div_done),
        .quotient (div_q),
        .sat      (div_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            cnt              <= '0;
            op_r             <= '0;
            op_g_half        <= '0;
            op_b             <= '0;
            res_r            <= GAIN_UNITY;
            bus.K_R          <= GAIN_UNITY;
            bus.K_G          <= GAIN_UNITY;
            bus.K_B          <= GAIN_UNITY;
            bus.valid_gain_o <= 1'b0;
            busy_o           <= 1'b0;
            frame_drop_o     <= 1'b0;
        end else begin
            frame_drop_o <= frame_end && (state != ST_IDLE);
            if (div_done && (state == ST_DIV_B)) begin
                res_r <= div_gain;
            end
            case (state)
                ST_IDLE: begin
                    if (frame_end) begin
                        op_r      <= nxt_r;
                        op_g_half <= nxt_g[SUM_W-1:1];
                        op_b      <= nxt_b;
                        cnt       <= '0;
                        state     <= ST_DIV_R;
                        busy_o    <= 1'b1;
                    end
                end
                ST_DIV_R: begin
                    if (cnt == DIV_LAST_CYC) begin
                        cnt   <= '0;
                        state <= ST_DIV_B;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_DIV_B: begin
                    if (cnt == DIV_LAST_CYC) begin
                        cnt   <= '0;
                        state <= ST_UPDATE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_UPDATE: begin
                    bus.K_R          <= res_r;
                    bus.K_G          <= GAIN_UNITY;
                    bus.K_B          <= div_gain;
                    bus.valid_gain_o <= 1'b1;
                    state            <= ST_IDLE;
                    busy_o           <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
